// File: rtl/cpu1_pkg.sv
// Shared CPU1 program-store types: writer FSM states and default word/address widths.
package cpu1_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/prog_writer_sync_edge.sv
// sync_edge: 2-flop synchroniser plus one-cycle rising-edge pulse.
// With PROG_WRITER_DEBOUNCE_EN defined, the synced level must hold DB_CYCLES cycles before it is seen.
module sync_edge
`ifdef PROG_WRITER_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
        end
    end

`ifdef PROG_WRITER_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Down-counter reloads whenever the synced input agrees with the accepted level.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = CW'(DB_CYCLES - 1);
        if (sync2_q != lvl_q) begin
            if (cnt_q == '0) lvl_d = sync2_q;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
            cnt_q <= CW'(DB_CYCLES - 1);
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync2_q;
`endif

    assign rise = lvl & ~prev_q;

endmodule

// File: rtl/prog_writer.sv
// Bit-serial writer for the CPU1 program store; combinational read port for the fetch path.
// Optional STB debounce enabled by defining PROG_WRITER_DEBOUNCE_EN.
module prog_writer
    import cpu1_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
`ifdef PROG_WRITER_DEBOUNCE_EN
    ,
    parameter int DB_CYCLES = 16
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          MODE,
    input  logic          DIN,
    input  logic          STB,
    input  logic [AW-1:0] RADR,
    output logic [DW-1:0] RDATA,
    output logic [AW-1:0] WADR,
    output logic [AW:0]   WORDS,
    output logic          LOADING,
    output logic          FULL
);

    localparam int          DEPTH   = 1 << AW;
    localparam int          BCW     = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic          mode_s1_q, mode_s_q;
    logic          din_s1_q, din_s_q;
    logic          accept;

    state_t        state_q, state_d;
    logic [AW-1:0] wadr_q, wadr_d;
    logic [AW:0]   words_q, words_d;
    logic [BCW-1:0] bitcnt_q, bitcnt_d;
    logic [DW-2:0] shreg_q, shreg_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] word;

    sync_edge
`ifdef PROG_WRITER_DEBOUNCE_EN
        #(.DB_CYCLES(DB_CYCLES))
`endif
        u_stb_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d_in  (STB),
        .rise  (accept)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_s1_q <= 1'b0;
            mode_s_q  <= 1'b0;
            din_s1_q  <= 1'b0;
            din_s_q   <= 1'b0;
        end else begin
            mode_s1_q <= MODE;
            mode_s_q  <= mode_s1_q;
            din_s1_q  <= DIN;
            din_s_q   <= din_s1_q;
        end
    end

    assign word = {shreg_q, din_s_q};

    // A MODE drop is checked before the accept pulse so a coincident bit is dropped.
    always_comb begin
        state_d  = state_q;
        wadr_d   = wadr_q;
        words_d  = words_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        mem_d    = mem_q;
        case (state_q)
            ST_RUN: begin
                if (mode_s_q) begin
                    state_d  = ST_LOAD;
                    wadr_d   = '0;
                    words_d  = '0;
                    bitcnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (!mode_s_q) begin
                    state_d  = ST_RUN;
                    bitcnt_d = '0;
                end else if (accept) begin
                    shreg_d = word[DW-2:0];
                    if (bitcnt_q == BCW'(DW - 1)) begin
                        mem_d[wadr_q] = word;
                        wadr_d        = wadr_q + 1'b1;
                        bitcnt_d      = '0;
                        if (words_q != DEPTH_W) words_d = words_q + 1'b1;
                        if (wadr_q == AW'(DEPTH - 1)) state_d = ST_FULL;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (!mode_s_q) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_RUN;
            wadr_q   <= '0;
            words_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wadr_q   <= wadr_d;
            words_q  <= words_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            mem_q    <= mem_d;
        end
    end

    assign RDATA   = mem_q[RADR];
    assign WADR    = wadr_q;
    assign WORDS   = words_q;
    assign LOADING = (state_q == ST_LOAD);
    assign FULL    = (state_q == ST_FULL);

endmodule

// File: tb/tb_prog_writer.sv
// Scoreboard bench for prog_writer: stimulus queues expected values, a negedge monitor checks them.
module tb_prog_writer;

    localparam int DW = 4;
    localparam int AW = 3;
`ifdef PROG_WRITER_DEBOUNCE_EN
    localparam int HOLD = 25;
`else
    localparam int HOLD = 6;
`endif

    localparam int K_RDATA   = 0;
    localparam int K_WADR    = 1;
    localparam int K_WORDS   = 2;
    localparam int K_LOADING = 3;
    localparam int K_FULL    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          MODE = 1'b0;
    logic          DIN = 1'b0;
    logic          STB = 1'b0;
    logic [AW-1:0] RADR = '0;
    logic [DW-1:0] RDATA;
    logic [AW-1:0] WADR;
    logic [AW:0]   WORDS;
    logic          LOADING;
    logic          FULL;

    typedef struct {
        int    kind;
        int    exp;
        string name;
    } chk_t;

    chk_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    prog_writer dut (
        .CLK     (CLK),
        .RST     (RST),
        .MODE    (MODE),
        .DIN     (DIN),
        .STB     (STB),
        .RADR    (RADR),
        .RDATA   (RDATA),
        .WADR    (WADR),
        .WORDS   (WORDS),
        .LOADING (LOADING),
        .FULL    (FULL)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            chk_t c;
            int   act;
            c = sb_q.pop_front();
            case (c.kind)
                K_RDATA:   act = int'(RDATA);
                K_WADR:    act = int'(WADR);
                K_WORDS:   act = int'(WORDS);
                K_LOADING: act = int'(LOADING);
                default:   act = int'(FULL);
            endcase
            vectors++;
            if (act != c.exp) begin
                miscompares++;
                $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input int radr, input int exp, input string name);
        RADR = AW'(radr);
        sb_q.push_back('{kind, exp, name});
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge CLK);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL %s: monitor timeout, got no check expected %0d", name, exp);
            sb_q.delete();
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic b);
        DIN = b;
        wait_cyc(2);
        STB = 1'b1;
        wait_cyc(HOLD);
        STB = 1'b0;
        wait_cyc(HOLD);
    endtask

    task automatic strobe_word(input logic [DW-1:0] w);
        for (int b = DW - 1; b >= 0; b--) strobe(w[b]);
    endtask

    task automatic set_mode(input logic m);
        MODE = m;
        wait_cyc(5);
    endtask

    task automatic check_reset_state(input string tag);
        expect_val(K_WADR, 0, 0, {tag, "_wadr"});
        expect_val(K_WORDS, 0, 0, {tag, "_words"});
        expect_val(K_LOADING, 0, 0, {tag, "_loading"});
        expect_val(K_FULL, 0, 0, {tag, "_full"});
        for (int a = 0; a < 8; a++) expect_val(K_RDATA, a, 0, $sformatf("%s_rdata%0d", tag, a));
    endtask

    initial begin
        wait_cyc(3);
        check_reset_state("rst_init");
        RST = 1'b1;
        wait_cyc(3);

        // single word 1011
        set_mode(1'b1);
        expect_val(K_LOADING, 0, 1, "sw_loading");
        expect_val(K_WADR, 0, 0, "sw_wadr0");
        strobe_word(4'b1011);
        expect_val(K_WADR, 0, 1, "sw_wadr1");
        expect_val(K_WORDS, 0, 1, "sw_words1");
        expect_val(K_RDATA, 0, 11, "sw_rd_load");
        set_mode(1'b0);
        expect_val(K_LOADING, 0, 0, "sw_run");
        expect_val(K_RDATA, 0, 11, "sw_rd_run");

        // partial word aborted by leaving load mode
        set_mode(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        set_mode(1'b0);
        set_mode(1'b1);
        strobe_word(4'b1100);
        expect_val(K_WADR, 0, 1, "pa_wadr");
        expect_val(K_WORDS, 0, 1, "pa_words");
        expect_val(K_RDATA, 0, 12, "pa_rd0");
        expect_val(K_RDATA, 1, 0, "pa_rd1");
        set_mode(1'b0);

        // strobes in run mode are ignored
        for (int i = 0; i < 10; i++) strobe(1'b1);
        expect_val(K_WADR, 0, 1, "run_wadr");
        expect_val(K_WORDS, 0, 1, "run_words");
        expect_val(K_RDATA, 0, 12, "run_rd0");
        expect_val(K_RDATA, 1, 0, "run_rd1");

        // fill the whole memory
        set_mode(1'b1);
        expect_val(K_WORDS, 0, 0, "fl_words0");
        for (int w = 0; w < 7; w++) strobe_word(DW'(w));
        expect_val(K_WORDS, 0, 7, "fl_words7");
        expect_val(K_FULL, 0, 0, "fl_notfull");
        strobe_word(4'h7);
        expect_val(K_FULL, 0, 1, "fl_full");
        expect_val(K_WORDS, 0, 8, "fl_words8");
        expect_val(K_LOADING, 0, 0, "fl_loading");
        expect_val(K_WADR, 0, 0, "fl_wadr_wrap");
        strobe_word(4'hF);
        expect_val(K_WORDS, 0, 8, "fl_9th_words");
        expect_val(K_RDATA, 0, 0, "fl_9th_rd0");
        expect_val(K_FULL, 0, 1, "fl_9th_full");
        set_mode(1'b0);
        expect_val(K_FULL, 0, 0, "fl_run_full");
        expect_val(K_LOADING, 0, 0, "fl_run_loading");
        for (int a = 0; a < 8; a++) expect_val(K_RDATA, a, a, $sformatf("fl_rd%0d", a));

        // reset in the middle of a load
        set_mode(1'b1);
        strobe_word(4'hF);
        strobe(1'b1);
        RST = 1'b0;
        #3;
        check_reset_state("rst_mid");
        MODE = 1'b0;
        wait_cyc(2);
        RST = 1'b1;
        wait_cyc(3);

`ifdef PROG_WRITER_DEBOUNCE_EN
        // short glitch must not shift a bit; clean pulses do
        set_mode(1'b1);
        DIN = 1'b1;
        wait_cyc(2);
        STB = 1'b1;
        wait_cyc(5);
        STB = 1'b0;
        wait_cyc(HOLD);
        expect_val(K_WORDS, 0, 0, "db_glitch_words");
        strobe_word(4'b1010);
        expect_val(K_WORDS, 0, 1, "db_words");
        expect_val(K_RDATA, 0, 10, "db_rd0");
        set_mode(1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_writer.md
Name: prog_writer

Overview:
- Writer side of the CPU1 program store: the CPU reads program words by address; this block writes them.
- Operator enters a program bit-serially from board switches while in load mode: DIN gives the data bit, a rising edge on STB commits it.
- Assembled words go into a small flop-based memory. The CPU fetch path reads that memory through a combinational read port in run mode.

Parameters:
- DW, 4, program word width in bits (must be >= 2)
- AW, 3, address width; DEPTH = 2**AW words
- DB_CYCLES, 16, debounce stable-count; used only when DEBOUNCE_EN is defined

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- MODE  in  1  1 = load mode, 0 = run mode (async switch)
- DIN  in  1  serial data bit (async switch)
- STB  in  1  bit-commit strobe (async button); rising edge commits DIN
- RADR  in  AW  CPU read address
- RDATA  out  DW  mem[RADR], combinational
- WADR  out  AW  current write pointer
- WORDS  out  AW+1  number of words written since entering load mode (0..DEPTH)
- LOADING  out  1  high in state LOAD
- FULL  out  1  high in state FULL

Behaviour:
- Reset (RST=0, async):
  - All mem words = 0, shift register = 0, bit counter = 0.
  - WADR = 0, WORDS = 0, state = RUN, LOADING = 0, FULL = 0.
- Input synchronisation:
  - MODE, DIN and STB each pass through a 2-flop synchroniser.
  - Rising-edge detect on synced STB produces a one-cycle accept pulse, 3 cycles after the STB rise (2 sync + 1 edge reg).
  - DIN is sampled from its synced copy on the accept cycle.
- FSM, states RUN, LOAD, FULL:
  - RUN -> LOAD when synced MODE=1. On entry: WADR=0, WORDS=0, bit counter=0. Memory contents are retained.
  - LOAD -> RUN when synced MODE=0. A partial word is discarded and the bit counter cleared; memory is unchanged.
  - LOAD -> FULL on the accept pulse that writes word DEPTH-1.
  - FULL -> RUN when synced MODE=0. In FULL, accept pulses are ignored.
- Accept pulse in LOAD:
  - Word is shifted MSB-first: shreg <= {shreg[DW-2:0], DIN_s}, bitcnt++.
  - When bitcnt == DW-1 the same edge writes mem[WADR] <= {shreg[DW-2:0], DIN_s}, then WADR++, WORDS++, bitcnt = 0.
  - The write is visible on RDATA the cycle after the accept pulse.
- WADR wraps to 0 after DEPTH-1 (never used, because FULL blocks further writes). WORDS saturates at DEPTH.
- Accept pulses in RUN are ignored.
- RDATA is valid in all states. The CPU must only fetch in RUN; a read during LOAD returns whatever is currently stored.
- Simultaneous MODE fall and accept pulse in the same cycle: the mode change wins and the bit is dropped.
- Reset asserted mid-load: everything returns to reset values, including memory.

Optional Feature:
- Macro: PROG_WRITER_DEBOUNCE_EN.
- Defined: synced STB must hold a new level for DB_CYCLES consecutive cycles before the edge detector sees it. Accept latency becomes 2 + DB_CYCLES + 1 cycles after a clean STB rise. Bounces shorter than DB_CYCLES produce no accept.
- Undefined: no debounce; every synced rising edge is accepted (the upstream divider is expected to filter).

Decomposition:
- Package cpu1_pkg holds:
  - the state enum (RUN, LOAD, FULL)
  - default DW/AW localparams shared with the CPU fetch path
- One sub-module, sync_edge:
  - 2-flop synchroniser plus rising-edge pulse
  - optional debounce counter under PROG_WRITER_DEBOUNCE_EN
  - instantiated for STB; plain 2-flop syncs are used for MODE and DIN.

Test Plan:
- Reset: RST=0 mid-operation -> all outputs 0, RDATA=0 for every RADR, state RUN.
- Single word: MODE=1, then strobe DIN bits 1,0,1,1 -> mem[0]=4'b1011, WADR=1, WORDS=1; RDATA at RADR=0 = 4'hB after MODE=0.
- Full memory: load 8 words 0x0..0x7 -> FULL=1, WORDS=8, LOADING=0; a 9th word's strobes change nothing; MODE=0 -> RUN, RDATA at RADR=5 = 4'h5.
- Partial abort: MODE=1, strobe 2 bits, MODE=0, MODE=1, strobe 1,1,0,0 -> mem[0]=4'hC (partial discarded), WADR=1.
- Strobes in RUN: STB toggled 10 times with MODE=0 -> memory, WADR and WORDS unchanged.
- Debounce (macro defined, DB_CYCLES=16): 5-cycle STB glitch -> no accept; clean 20-cycle pulse -> exactly one bit shifted.
